// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - memlen encodings, arbiter states and command struct
package dmem_arbiter_pkg;

  // Loads and stores share funct3-style codes; mem_we tells them apart.
  localparam logic [2:0] MEMLEN_LB  = 3'b000;
  localparam logic [2:0] MEMLEN_LH  = 3'b001;
  localparam logic [2:0] MEMLEN_LW  = 3'b010;
  localparam logic [2:0] MEMLEN_LBU = 3'b100;
  localparam logic [2:0] MEMLEN_LHU = 3'b101;
  localparam logic [2:0] MEMLEN_SB  = 3'b000;
  localparam logic [2:0] MEMLEN_SH  = 3'b001;
  localparam logic [2:0] MEMLEN_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_LAST,
    ST_DBG_LAST,
    ST_DBG_LOCK
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  memlen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way round-robin pick between CPU and debug requests
module dmem_rr_pick (
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic prefer_cpu,
  output logic pick_cpu,
  output logic pick_dbg
);

  always_comb begin
    pick_cpu = cpu_req && (!dbg_req || prefer_cpu);
    pick_dbg = dbg_req && !pick_cpu;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug data-memory arbiter with debug burst lock
// and CPU starvation guard; reads return registered data one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_memlen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_memlen,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_ready,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_we,
  output logic [2:0]  mem_memlen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [31:0] ADDR_MASK =
    (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ADDR_WIDTH) - 64'd1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [31:0]         dbg_rdata_q, dbg_rdata_d;

  logic     cpu_elig, prefer_cpu, pick_cpu, pick_dbg;
  logic     starved, grant_cpu, grant_dbg;
  mem_cmd_t cmd;

  // A held lock hides the CPU from the round-robin; only starvation overrides it.
  always_comb begin
    cpu_elig   = cpu_req && !((state_q == ST_DBG_LOCK) && dbg_lock);
    prefer_cpu = (state_q == ST_DBG_LAST) || (state_q == ST_DBG_LOCK);
  end

  dmem_rr_pick u_rr_pick (
    .cpu_req    (cpu_elig),
    .dbg_req    (dbg_req),
    .prefer_cpu (prefer_cpu),
    .pick_cpu   (pick_cpu),
    .pick_dbg   (pick_dbg)
  );

  always_comb begin
    starved   = cpu_req && (starve_q >= STARVE_MAX);
    grant_cpu = rst && (starved || pick_cpu);
    grant_dbg = rst && !starved && pick_dbg;

    state_d = state_q;
    if (grant_dbg) begin
      state_d = dbg_lock ? ST_DBG_LOCK : ST_DBG_LAST;
    end else if (grant_cpu) begin
      state_d = ST_CPU_LAST;
    end else if ((state_q == ST_DBG_LOCK) && !dbg_lock) begin
      state_d = ST_DBG_LAST;
    end

    starve_d = starve_q;
    if (!cpu_req || grant_cpu) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    cmd = '0;
    if (grant_cpu) begin
      cmd = '{we: cpu_we, memlen: cpu_memlen, addr: cpu_addr & ADDR_MASK, wdata: cpu_wdata};
    end else if (grant_dbg) begin
      cmd = '{we: dbg_we, memlen: dbg_memlen, addr: dbg_addr & ADDR_MASK, wdata: dbg_wdata};
    end

    cpu_rvalid_d = grant_cpu && !cpu_we;
    dbg_rvalid_d = grant_dbg && !dbg_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_ready  = grant_cpu;
  assign dbg_ready  = grant_dbg;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_we     = cmd.we;
  assign mem_memlen = cmd.memlen;
  assign mem_addr   = cmd.addr;
  assign mem_wdata  = cmd.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a byte-array Dmem model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid;
  logic [2:0]  cpu_memlen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_ready, dbg_rvalid;
  logic [2:0]  dbg_memlen;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_we;
  logic [2:0]  mem_memlen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_memlen(cpu_memlen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_memlen(dbg_memlen),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_memlen(mem_memlen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Dmem: little-endian bytes, combinational load with sign/zero extension.
  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    case (mem_memlen)
      MEMLEN_LB:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      MEMLEN_LBU: mem_rdata = {24'h0, mem[a0]};
      MEMLEN_LH:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      MEMLEN_LHU: mem_rdata = {16'h0, mem[a1], mem[a0]};
      MEMLEN_LW:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      default:    mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 4 || i == 8) ? 8'h64 : 8'h00;
    end else if (mem_we) begin
      case (mem_memlen)
        MEMLEN_SB: mem[a0] <= mem_wdata[7:0];
        MEMLEN_SH: begin mem[a0] <= mem_wdata[7:0]; mem[a1] <= mem_wdata[15:8]; end
        MEMLEN_SW: begin
          mem[a0] <= mem_wdata[7:0];   mem[a1] <= mem_wdata[15:8];
          mem[a2] <= mem_wdata[23:16]; mem[a3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] alt_dbg;
    logic [6:0] lock_dbg;
    logic [2:0] guard_cpu;
    alt_dbg   = 6'b010101;
    lock_dbg  = 7'b1101111;
    guard_cpu = 3'b100;

    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_memlen = MEMLEN_LW; cpu_addr = 32'h4; cpu_wdata = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_memlen = MEMLEN_LW; dbg_addr = 32'h8; dbg_wdata = 32'h0;
    dbg_lock = 1'b0;

    // Reset state with both ports requesting
    @(negedge clk); #1;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);

    // Both read from IDLE: debug first, then CPU
    @(negedge clk); rst = 1'b1; #1;
    chk("r0_dbg_ready", dbg_ready, 1);
    chk("r0_cpu_ready", cpu_ready, 0);
    chk("r0_mem_addr", mem_addr, 32'h8);
    chk("r0_mem_memlen", mem_memlen, MEMLEN_LW);
    @(negedge clk); dbg_req = 1'b0; #1;
    chk("r1_dbg_rvalid", dbg_rvalid, 1);
    chk("r1_dbg_rdata", dbg_rdata, 32'h64);
    chk("r1_cpu_ready", cpu_ready, 1);
    chk("r1_mem_addr", mem_addr, 32'h4);
    chk("r1_cpu_rvalid", cpu_rvalid, 0);
    @(negedge clk); cpu_req = 1'b0; #1;
    chk("r2_cpu_rvalid", cpu_rvalid, 1);
    chk("r2_cpu_rdata", cpu_rdata, 32'h64);
    chk("r2_dbg_rvalid", dbg_rvalid, 0);
    chk("r2_dbg_rdata_hold", dbg_rdata, 32'h64);
    chk("r2_idle_mem_addr", mem_addr, 0);
    chk("r2_idle_mem_memlen", mem_memlen, 0);

    // Continuous both-request without lock alternates D,C,D,C,D,C
    @(negedge clk); cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt%0d_dbg_ready", i), dbg_ready, alt_dbg[i]);
      chk($sformatf("alt%0d_cpu_ready", i), cpu_ready, !alt_dbg[i]);
      if (i > 0) chk($sformatf("alt%0d_dbg_rvalid", i), dbg_rvalid, alt_dbg[i-1]);
      @(negedge clk);
    end

    // Lock held: four CPU denials, fifth cycle goes to CPU, then debug resumes
    dbg_lock = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("lock%0d_dbg_ready", i), dbg_ready, lock_dbg[i]);
      chk($sformatf("lock%0d_cpu_ready", i), cpu_ready, !lock_dbg[i]);
      @(negedge clk);
    end

    // Lock held, debug idle: CPU still blocked until the counter saturates
    dbg_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("guard%0d_cpu_ready", i), cpu_ready, guard_cpu[i]);
      chk($sformatf("guard%0d_dbg_ready", i), dbg_ready, 0);
      @(negedge clk);
    end
    cpu_req = 1'b0; dbg_lock = 1'b0;

    // CPU store then signed/unsigned byte loads; upper address bits are masked
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_memlen = MEMLEN_SW; cpu_addr = 32'h20; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("sw_cpu_ready", cpu_ready, 1);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_mem_addr", mem_addr, 32'h20);
    @(negedge clk); cpu_we = 1'b0; cpu_memlen = MEMLEN_LB; cpu_addr = 32'h23; cpu_wdata = 32'h0; #1;
    chk("sw_no_rvalid", cpu_rvalid, 0);
    chk("lb_mem_we", mem_we, 0);
    @(negedge clk); cpu_memlen = MEMLEN_LBU; cpu_addr = 32'h1234_5623; #1;
    chk("lb_cpu_rvalid", cpu_rvalid, 1);
    chk("lb_cpu_rdata", cpu_rdata, 32'hFFFF_FFDE);
    chk("lbu_mem_addr_masked", mem_addr, 32'h23);
    @(negedge clk); cpu_req = 1'b0; #1;
    chk("lbu_cpu_rdata", cpu_rdata, 32'h0000_00DE);
    @(negedge clk); #1;
    chk("idle_cpu_rvalid", cpu_rvalid, 0);
    chk("idle_cpu_rdata_hold", cpu_rdata, 32'h0000_00DE);

    // Reset right after a debug read acceptance drops the response
    dbg_req = 1'b1; dbg_addr = 32'h8; dbg_memlen = MEMLEN_LW; #1;
    chk("pre_rst_dbg_ready", dbg_ready, 1);
    @(posedge clk); #1; rst = 1'b0; dbg_req = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_dbg_rvalid", dbg_rvalid, 0);
    chk("mid_rst_dbg_rdata", dbg_rdata, 0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 0);
    cpu_req = 1'b1; dbg_req = 1'b1; #1;
    chk("mid_rst_cpu_ready", cpu_ready, 0);
    chk("mid_rst_dbg_ready", dbg_ready, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("post_rst_dbg_rvalid", dbg_rvalid, 0);
    chk("post_rst_dbg_ready", dbg_ready, 1);
    chk("post_rst_cpu_ready", cpu_ready, 0);
    @(negedge clk); cpu_req = 1'b0; dbg_req = 1'b0; #1;
    chk("post_rst_dbg_rdata", dbg_rdata, 32'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
